// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction queue between the fetch arbiter and the Identify stage.
//   Fetched 32-bit words (big-endian numbering [0:31], opcode = [0:5]) are
//   buffered in a circular word buffer. The output register presents one
//   complete instruction at a time: a plain word goes out as the suffix with
//   a zero prefix; a prefixed word (opcode 1) goes out together with the
//   word after it, and the pair is never split.
//
// Handshakes:
//   fetch side : a word transfers on a rising edge where i_fetch_valid and
//                o_fetch_ready are both 1. o_fetch_ready depends only on the
//                registered count, never on i_fetch_valid.
//   output side: o_id_valid=1 means o_id_prefix/o_id_suffix hold an
//                instruction. It is consumed on an edge where i_en=1 and
//                i_id_stall=0; otherwise all o_id_* hold.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_flush               discard buffered and presented words (sync)
//   i_fetch_valid/_instr  incoming word
//   o_fetch_ready         queue accepts a word this cycle
//   i_en, i_id_stall      Identify enable and stall
//   o_id_valid/_prefix/_suffix  presented instruction
//   o_count               words held in the buffer (output reg excluded)

module fetch_queue #(
  parameter int DEPTH = 4,
  localparam int W    = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_fetch_valid,
  input  logic [0:31]   i_fetch_instr,
  output logic          o_fetch_ready,
  input  logic          i_en,
  input  logic          i_id_stall,
  output logic          o_id_valid,
  output logic [0:31]   o_id_prefix,
  output logic [0:31]   o_id_suffix,
  output logic [W-1:0]  o_count
);

  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [W-1:0]  FULL_CNT = W'(DEPTH);

  logic [0:31]   buf_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [W-1:0]  count_q,  count_d;
  logic          valid_q,  valid_d;
  logic [0:31]   prefix_q, prefix_d;
  logic [0:31]   suffix_q, suffix_d;

  logic          push;
  logic          load;
  logic [1:0]    pop;
  logic [PW-1:0] rd_nxt;
  logic [PW-1:0] rd_nxt2;
  logic [0:31]   head_word;
  logic [0:31]   next_word;
  logic          head_pfx;
  logic          avail;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  // Ready is low throughout reset, then tracks the pre-edge count only, so a
  // full queue refuses a push even in a cycle where it also pops.
  assign o_fetch_ready = i_rst_n & (count_q < FULL_CNT);
  assign push          = i_fetch_valid & o_fetch_ready;

  assign rd_nxt    = inc_ptr(rd_ptr_q);
  assign rd_nxt2   = inc_ptr(rd_nxt);
  assign head_word = buf_q[rd_ptr_q];
  assign next_word = buf_q[rd_nxt];
  assign head_pfx  = (head_word[0:5] == 6'b000001);

  // A lone prefix at the head waits until its suffix has arrived.
  assign avail = head_pfx ? (count_q >= W'(2)) : (count_q != '0);
  assign load  = avail & i_en & (~valid_q | ~i_id_stall);
  assign pop   = load ? (head_pfx ? 2'd2 : 2'd1) : 2'd0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    prefix_d = prefix_q;
    suffix_d = suffix_q;

    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      prefix_d = '0;
      suffix_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = inc_ptr(wr_ptr_q);
      end
      if (load) begin
        rd_ptr_d = head_pfx ? rd_nxt2 : rd_nxt;
        valid_d  = 1'b1;
        // A suffix that is itself opcode 1 is passed through unchanged;
        // Identify treats it as an unknown instruction.
        prefix_d = head_pfx ? head_word : '0;
        suffix_d = head_pfx ? next_word : head_word;
      end else if (valid_q && i_en && !i_id_stall) begin
        valid_d = 1'b0;
      end
      count_d = count_q + W'(push) - W'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      prefix_q <= '0;
      suffix_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      prefix_q <= prefix_d;
      suffix_q <= suffix_d;
    end
  end

  // A flushed cycle must not write the buffer: its word is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (push && !i_flush) begin
      buf_q[wr_ptr_q] <= i_fetch_instr;
    end
  end

  assign o_id_valid  = valid_q;
  assign o_id_prefix = prefix_q;
  assign o_id_suffix = suffix_q;
  assign o_count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4). Inputs change 1 time unit after
// a rising edge; outputs are checked at the same point.

module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int W     = $clog2(DEPTH + 1);

  logic          i_clk;
  logic          i_rst_n;
  logic          i_flush;
  logic          i_fetch_valid;
  logic [0:31]   i_fetch_instr;
  logic          o_fetch_ready;
  logic          i_en;
  logic          i_id_stall;
  logic          o_id_valid;
  logic [0:31]   o_id_prefix;
  logic [0:31]   o_id_suffix;
  logic [W-1:0]  o_count;

  int n_cmp;
  int n_err;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_flush       (i_flush),
    .i_fetch_valid (i_fetch_valid),
    .i_fetch_instr (i_fetch_instr),
    .o_fetch_ready (o_fetch_ready),
    .i_en          (i_en),
    .i_id_stall    (i_id_stall),
    .o_id_valid    (o_id_valid),
    .o_id_prefix   (o_id_prefix),
    .o_id_suffix   (o_id_suffix),
    .o_count       (o_count)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] p,
                         input logic [31:0] s, input int c);
    chk({tag, "_valid"},  32'(o_id_valid), 32'(v));
    chk({tag, "_prefix"}, o_id_prefix, p);
    chk({tag, "_suffix"}, o_id_suffix, s);
    chk({tag, "_count"},  32'(o_count), 32'(c));
  endtask

  task automatic drive(input logic v, input logic [31:0] w);
    i_fetch_valid = v;
    i_fetch_instr = w;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    i_rst_n = 1'b0;
    i_flush = 1'b0;
    i_en = 1'b1;
    i_id_stall = 1'b0;
    drive(1'b0, 32'h0);

    // 1 reset
    tick(); tick();
    chk_out("rst", 1'b0, 32'h0, 32'h0, 0);
    chk("rst_ready", 32'(o_fetch_ready), 32'd0);
    i_rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(o_fetch_ready), 32'd1);

    // 2 single plain word, one-cycle latency
    drive(1'b1, 32'h48032BFB);
    tick();
    drive(1'b0, 32'h0);
    chk_out("t2_e", 1'b0, 32'h0, 32'h0, 1);
    tick();
    chk_out("t2_e1", 1'b1, 32'h0, 32'h48032BFB, 0);

    // 3 lone prefix waits, then pairs with its suffix
    drive(1'b1, 32'h04000000);
    tick();
    drive(1'b0, 32'h0);
    chk("t3_pfx_valid", 32'(o_id_valid), 32'd0);
    chk("t3_pfx_count", 32'(o_count), 32'd1);
    tick();
    chk("t3_wait_valid", 32'(o_id_valid), 32'd0);
    chk("t3_wait_count", 32'(o_count), 32'd1);
    drive(1'b1, 32'h38600005);
    tick();
    drive(1'b0, 32'h0);
    chk("t3_sfx_count", 32'(o_count), 32'd2);
    tick();
    chk_out("t3_pair", 1'b1, 32'h04000000, 32'h38600005, 0);

    // 4 stall, fill to DEPTH, fifth word refused, drain in order across wrap
    i_id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10000001 + 32'(i));
      tick();
      chk("t4_fill_suffix", o_id_suffix, 32'h38600005);
    end
    chk_out("t4_full", 1'b1, 32'h04000000, 32'h38600005, 4);
    chk("t4_full_ready", 32'(o_fetch_ready), 32'd0);
    drive(1'b1, 32'h100000FF);
    tick();
    chk_out("t4_refuse", 1'b1, 32'h04000000, 32'h38600005, 4);
    drive(1'b0, 32'h0);
    i_id_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("t4_drain", 1'b1, 32'h0, 32'h10000001 + 32'(i), 3 - i);
    end
    tick();
    chk("t4_empty_valid", 32'(o_id_valid), 32'd0);
    chk("t4_empty_count", 32'(o_count), 32'd0);

    // 5 flush with count=3, output valid and a word presented
    i_id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h20000000 + 32'(i));
      tick();
    end
    chk_out("t5_pre", 1'b1, 32'h0, 32'h20000000, 3);
    i_flush = 1'b1;
    drive(1'b1, 32'h200000AA);
    tick();
    chk_out("t5_flush", 1'b0, 32'h0, 32'h0, 0);
    i_flush = 1'b0;
    i_id_stall = 1'b0;
    drive(1'b0, 32'h0);
    tick();
    chk_out("t5_after", 1'b0, 32'h0, 32'h0, 0);

    // 6 full queue, stall released, same-cycle push refused then refilled
    i_id_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h30000000 + 32'(i));
      tick();
    end
    chk_out("t6_full", 1'b1, 32'h0, 32'h30000000, 4);
    i_id_stall = 1'b0;
    drive(1'b1, 32'h30000005);
    chk("t6_ready0", 32'(o_fetch_ready), 32'd0);
    tick();
    chk_out("t6_pop", 1'b1, 32'h0, 32'h30000001, 3);
    chk("t6_ready1", 32'(o_fetch_ready), 32'd1);
    tick();
    drive(1'b0, 32'h0);
    chk_out("t6_refill", 1'b1, 32'h0, 32'h30000002, 3);
    for (int i = 3; i < 6; i++) begin
      tick();
      chk_out("t6_drain", 1'b1, 32'h0, 32'h30000000 + 32'(i), 5 - i);
    end
    tick();
    chk("t6_empty_valid", 32'(o_id_valid), 32'd0);

    // 7 prefix whose suffix is also opcode 1 is still paired
    drive(1'b1, 32'h04000001);
    tick();
    drive(1'b1, 32'h04000002);
    tick();
    drive(1'b0, 32'h0);
    chk("t7_wait_valid", 32'(o_id_valid), 32'd0);
    tick();
    chk_out("t7_pair", 1'b1, 32'h04000001, 32'h04000002, 0);

    // 8 i_en=0 freezes the output stage
    i_en = 1'b0;
    drive(1'b1, 32'h50000000);
    tick();
    drive(1'b0, 32'h0);
    tick();
    chk_out("t8_frozen", 1'b1, 32'h04000001, 32'h04000002, 1);
    i_en = 1'b1;
    tick();
    chk_out("t8_resume", 1'b1, 32'h0, 32'h50000000, 0);

    // 9 async reset mid-operation, first push on first edge after release
    i_id_stall = 1'b1;
    drive(1'b1, 32'h60000000);
    tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    chk_out("t9_arst", 1'b0, 32'h0, 32'h0, 0);
    chk("t9_arst_ready", 32'(o_fetch_ready), 32'd0);
    tick();
    i_rst_n = 1'b1;
    i_id_stall = 1'b0;
    drive(1'b1, 32'h60000001);
    tick();
    drive(1'b0, 32'h0);
    chk("t9_first_push", 32'(o_count), 32'd1);
    tick();
    chk_out("t9_out", 1'b1, 32'h0, 32'h60000001, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
